// File: rtl/vlc_occ_sched_pkg.sv
// ---------------------------------------------------------------------------
// vlc_occ_sched_pkg
// Shared definitions for the run/level occurrence scheduler:
//   - THIRD_FIELD_SIZE : default width of run/level values and log data
//   - OCC_RUN/OCC_LEVEL: occurrence type driven on log_type
//   - sch_state_t      : scheduler FSM encoding (IDLE/RUN/LEVEL)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package vlc_occ_sched_pkg;

    localparam int THIRD_FIELD_SIZE = 8;

    localparam logic OCC_RUN   = 1'b0;
    localparam logic OCC_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_RUN   = 2'd1,
        SCH_LEVEL = 2'd2
    } sch_state_t;

endpackage

// File: rtl/vlc_tok_fifo.sv
// ---------------------------------------------------------------------------
// vlc_tok_fifo
// Synchronous show-ahead FIFO holding packed {last, run, level} tokens.
// Ports:
//   clk, rst        : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din   : write request and data (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_dout          : head entry, valid whenever o_empty is low
//   o_full, o_empty : occupancy flags
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vlc_tok_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/vlc_occ_sched.sv
// ---------------------------------------------------------------------------
// vlc_occ_sched
// Sequences buffered run/level tokens into the log datapath, one field per
// beat: a run beat (type 0) when run != 0, then the level beat (type 1).
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   tok_valid/ready : token handshake; tok_run, tok_level, tok_last payload
//   out_ready       : downstream accepts the current beat
//   log_din_valid, log_type, log_data : registered beat to the log block
//   blk_done, blk_beats : end-of-block pulse and beat count of that block
//   err_zero_level  : sticky flag, a token with level 0 was accepted
//   busy            : FIFO non-empty or a beat is pending
//   dbg_state       : current scheduler FSM state
// Handshake: a transfer happens on a posedge where valid && ready are both
// high; a producer holds its payload stable while valid is high and ready low.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vlc_occ_sched
    import vlc_occ_sched_pkg::*;
#(
    parameter int DATA_W = THIRD_FIELD_SIZE,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [DATA_W-1:0] tok_run,
    input  logic [DATA_W-1:0] tok_level,
    input  logic              tok_last,
    input  logic              out_ready,
    output logic              log_din_valid,
    output logic              log_type,
    output logic [DATA_W-1:0] log_data,
    output logic              blk_done,
    output logic [CNT_W-1:0]  blk_beats,
    output logic              err_zero_level,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int TOK_W = 2*DATA_W + 1;

    sch_state_t        r_state;
    sch_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_cur_level;
    logic              r_cur_last;
    logic              r_log_valid;
    logic              r_log_type;
    logic [DATA_W-1:0] r_log_data;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_blk_done;
    logic [CNT_W-1:0]  r_blk_beats;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [TOK_W-1:0]  w_head;
    logic [DATA_W-1:0] w_head_run;
    logic [DATA_W-1:0] w_head_level;
    logic              w_head_last;
    logic              w_accept;
    logic              w_load;
    logic              w_clear;
    logic              w_ld_type;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_blk_end;

    // Gated by rst so every output reads 0 while reset is held.
    assign tok_ready = rst && !w_full;
    assign w_push    = tok_valid && tok_ready;
    assign w_accept  = r_log_valid && out_ready;

    vlc_tok_fifo #(.W(TOK_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({tok_last, tok_run, tok_level}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_last  = w_head[TOK_W-1];
    assign w_head_run   = w_head[2*DATA_W-1:DATA_W];
    assign w_head_level = w_head[DATA_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= SCH_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; popping in LEVEL on accept keeps beats contiguous
    // across token boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            SCH_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_head_run != '0) ? SCH_RUN : SCH_LEVEL;
                end
            end
            SCH_RUN: begin
                if (w_accept) w_state_nxt = SCH_LEVEL;
            end
            SCH_LEVEL: begin
                if (w_accept) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = (w_head_run != '0) ? SCH_RUN : SCH_LEVEL;
                    end else begin
                        w_state_nxt = SCH_IDLE;
                    end
                end
            end
            default: w_state_nxt = SCH_IDLE;
        endcase
    end

    // Output decode: which beat (if any) is loaded into the output register.
    always_comb begin
        w_load    = w_pop || ((r_state == SCH_RUN) && w_accept);
        w_clear   = (r_state == SCH_LEVEL) && w_accept && w_empty;
        w_ld_type = OCC_LEVEL;
        w_ld_data = r_cur_level;
        if (w_pop) begin
            if (w_head_run != '0) begin
                w_ld_type = OCC_RUN;
                w_ld_data = w_head_run;
            end else begin
                w_ld_type = OCC_LEVEL;
                w_ld_data = w_head_level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_log_valid <= 1'b0;
            r_log_type  <= 1'b0;
            r_log_data  <= '0;
            r_cur_level <= '0;
            r_cur_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_log_valid <= 1'b1;
                r_log_type  <= w_ld_type;
                r_log_data  <= w_ld_data;
            end else if (w_clear) begin
                r_log_valid <= 1'b0;
            end
            if (w_pop) begin
                r_cur_level <= w_head_level;
                r_cur_last  <= w_head_last;
            end
        end
    end

    // Block accounting: the level beat of a last token closes the block.
    assign w_blk_end = w_accept && (r_state == SCH_LEVEL) && r_cur_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat_cnt  <= '0;
            r_blk_done  <= 1'b0;
            r_blk_beats <= '0;
            r_err       <= 1'b0;
        end else begin
            r_blk_done <= w_blk_end;
            if (w_blk_end) begin
                r_blk_beats <= r_beat_cnt + CNT_W'(1);
                r_beat_cnt  <= '0;
            end else if (w_accept) begin
                r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
            end
            if (w_push && (tok_level == '0)) r_err <= 1'b1;
        end
    end

    assign log_din_valid  = r_log_valid;
    assign log_type       = r_log_type;
    assign log_data       = r_log_data;
    assign blk_done       = r_blk_done;
    assign blk_beats      = r_blk_beats;
    assign err_zero_level = r_err;
    assign busy           = !w_empty || r_log_valid;
    assign dbg_state      = r_state;

endmodule
